// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch (IF) and data memory (DM).
// One access at a time: grant in IDLE, SRAM_LAT cycles of ACCESS, one DONE cycle
// carrying the completion pulse. Conflicts alternate between the two requesters.
module mem_port_arbiter #(
   parameter int SRAM_LAT = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_be,
   output logic                dm_gnt,
   output logic                dm_done,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                sram_ce,
   output logic                sram_we,
   output logic [DATA_W/8-1:0] sram_be,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   input  logic [DATA_W-1:0]   sram_rdata,
   output logic                busy
);

   localparam int         BE_W     = DATA_W / 8;
   localparam logic       OWN_IF   = 1'b0;
   localparam logic       OWN_DM   = 1'b1;
   localparam logic [3:0] CNT_INIT = 4'(SRAM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [3:0]        cnt;
   logic              owner;
   logic              last_owner;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;
   logic [DATA_W-1:0] lat_wdata;
   logic [BE_W-1:0]   lat_be;
   logic              grant_if;
   logic              grant_dm;

   // Arbitration: only in IDLE, the requester that did not own the last access wins a tie
   always_comb begin
      grant_if = 1'b0;
      grant_dm = 1'b0;
      if (state == IDLE && !rst) begin
         if (if_req && dm_req) begin
            if (last_owner == OWN_IF) grant_dm = 1'b1;
            else                      grant_if = 1'b1;
         end else if (dm_req) begin
            grant_dm = 1'b1;
         end else if (if_req) begin
            grant_if = 1'b1;
         end
      end
   end

   // Next-state and output decode; SRAM pins only carry latched values during ACCESS
   always_comb begin
      next_state = state;
      if_gnt     = grant_if;
      dm_gnt     = grant_dm;
      if_rvalid  = 1'b0;
      dm_done    = 1'b0;
      sram_ce    = 1'b0;
      sram_we    = 1'b0;
      sram_be    = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      case (state)
         IDLE: begin
            if (grant_if || grant_dm) next_state = ACCESS;
         end
         ACCESS: begin
            sram_ce    = 1'b1;
            sram_we    = lat_we;
            sram_be    = lat_be;
            sram_addr  = lat_addr;
            sram_wdata = lat_wdata;
            if (cnt == 4'd0) next_state = DONE;
         end
         DONE: begin
            if_rvalid  = (owner == OWN_IF);
            dm_done    = (owner == OWN_DM);
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // State register; reset abandons any access in flight
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Request latch, latency counter and read-data capture on the final ACCESS cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         owner      <= OWN_IF;
         last_owner <= OWN_IF;
         lat_addr   <= '0;
         lat_we     <= 1'b0;
         lat_wdata  <= '0;
         lat_be     <= '0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
      end else begin
         if (grant_if || grant_dm) begin
            owner      <= grant_dm;
            last_owner <= grant_dm;
            cnt        <= CNT_INIT;
            lat_addr   <= grant_dm ? dm_addr : if_addr;
            lat_we     <= grant_dm && dm_we;
            lat_wdata  <= grant_dm ? dm_wdata : '0;
            lat_be     <= (grant_dm && dm_we) ? dm_be : '1;
         end
         if (state == ACCESS) begin
            if (cnt != 4'd0) begin
               cnt <= cnt - 4'd1;
            end else if (!lat_we) begin
               if (owner == OWN_IF) if_rdata <= sram_rdata;
               else                 dm_rdata <= sram_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: SRAM model, scoreboard of expected completions,
// a per-cycle monitor of the SRAM pins, and a second SRAM_LAT=1 instance.
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_gnt, dm_done;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;
   logic        sram_ce, sram_we, busy;
   logic [3:0]  sram_be;
   logic [31:0] sram_addr, sram_wdata, sram_rdata;

   logic        b_if_req, b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_done;
   logic [31:0] b_if_rdata, b_dm_rdata, b_sram_addr, b_sram_wdata, b_sram_rdata;
   logic        b_sram_ce, b_sram_we, b_busy;
   logic [3:0]  b_sram_be;

   // Free-running clock
   always #5 clk = ~clk;

   mem_port_arbiter #(.SRAM_LAT(LAT), .ADDR_W(32), .DATA_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
      .sram_ce(sram_ce), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
   );

   mem_port_arbiter #(.SRAM_LAT(1), .ADDR_W(32), .DATA_W(32)) u_dut_lat1 (
      .clk(clk), .rst(rst),
      .if_req(b_if_req), .if_addr(32'h0000_0040), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
      .if_rdata(b_if_rdata),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0), .dm_be(4'h0),
      .dm_gnt(b_dm_gnt), .dm_done(b_dm_done), .dm_rdata(b_dm_rdata),
      .sram_ce(b_sram_ce), .sram_we(b_sram_we), .sram_be(b_sram_be), .sram_addr(b_sram_addr),
      .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata), .busy(b_busy)
   );

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   // Cycle counter used to timestamp grants and completions
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // SRAM model: word array indexed by addr[9:2], preloaded words, byte-merged writes.
   // Read data is only meaningful in the last ACCESS cycle; garbage elsewhere.
   logic [31:0] wmem [0:255];
   bit          wvalid [0:255];
   int          acc_n = 0;

   function automatic logic [31:0] preload(input logic [7:0] idx);
      case (idx)
         8'h00:   return 32'h02C0_0421;
         8'h80:   return 32'hCAFE_0200;
         default: return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Count consecutive chip-enable cycles to find the last ACCESS cycle
   always @(posedge clk) acc_n <= sram_ce ? acc_n + 1 : 0;

   // Store path of the SRAM model
   always @(posedge clk) begin
      if (sram_ce && sram_we) begin
         wmem[sram_addr[9:2]]   <= merge(wvalid[sram_addr[9:2]] ? wmem[sram_addr[9:2]]
                                         : preload(sram_addr[9:2]), sram_wdata, sram_be);
         wvalid[sram_addr[9:2]] <= 1'b1;
      end
   end

   assign sram_rdata = (sram_ce && !sram_we && acc_n == LAT - 1)
                       ? (wvalid[sram_addr[9:2]] ? wmem[sram_addr[9:2]] : preload(sram_addr[9:2]))
                       : 32'hBAD0_BAD0;

   assign b_sram_rdata = b_sram_ce ? ~b_sram_addr : 32'h0;

   // Scoreboard of expected completions and the access currently expected on the pins
   typedef struct {
      logic [31:0] data;
      int          cyc;
      bit          load;
   } exp_t;

   exp_t        if_q[$];
   exp_t        dm_q[$];
   int          g_cyc = -100;
   int          abort_cyc = 1 << 30;
   logic [31:0] cur_addr, cur_wdata;
   logic        cur_we;
   logic [3:0]  cur_be;
   logic [31:0] exp_if_rdata = 32'h0;
   logic [31:0] exp_dm_rdata = 32'h0;

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pushGrant(input bit is_dm, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input logic [31:0] data);
      exp_t e;
      g_cyc     = cyc;
      abort_cyc = 1 << 30;
      cur_addr  = addr;
      cur_we    = we;
      cur_be    = we ? be : 4'hF;
      cur_wdata = wdata;
      e.data    = data;
      e.cyc     = cyc + LAT + 1;
      e.load    = !we;
      if (is_dm) dm_q.push_back(e);
      else       if_q.push_back(e);
   endtask

   // Raise one request, wait (bounded) for its grant, record the expected result, then drop it
   // and scramble the request fields so any use of un-latched inputs shows up on the pins.
   task automatic applyStimulus(input bit is_dm, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] data, input int exp_gcyc, output int gcyc);
      int  w;
      bit  got;
      w = 0;
      if (is_dm) begin
         dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_be = be;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      #1;
      got = is_dm ? dm_gnt : if_gnt;
      while (!got && w < 20) begin
         nextCycle();
         #1;
         got = is_dm ? dm_gnt : if_gnt;
         w++;
      end
      gcyc = cyc;
      if (got) begin
         pushGrant(is_dm, we, addr, wdata, be, data);
         checkOutput("gnt_cycle", 32'(gcyc), 32'(exp_gcyc));
      end else begin
         checkOutput("gnt_timeout", 32'd0, 32'd1);
      end
      nextCycle();
      if (is_dm) begin
         dm_req = 1'b0; dm_we = ~we; dm_addr = ~addr; dm_wdata = ~wdata; dm_be = ~be;
      end else begin
         if_req = 1'b0; if_addr = ~addr;
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      nextCycle();
      nextCycle();
      rst = 1'b0;
      g_cyc     = -100;
      abort_cyc = 1 << 30;
   endtask

   task automatic waitUntil(input int c);
      int w;
      w = 0;
      while (cyc < c && w < 100) begin
         nextCycle();
         w++;
      end
   endtask

   task automatic checkReset();
      #1;
      checkOutput("rst_if_gnt",     32'(if_gnt),     32'd0);
      checkOutput("rst_dm_gnt",     32'(dm_gnt),     32'd0);
      checkOutput("rst_if_rvalid",  32'(if_rvalid),  32'd0);
      checkOutput("rst_dm_done",    32'(dm_done),    32'd0);
      checkOutput("rst_if_rdata",   if_rdata,        32'd0);
      checkOutput("rst_dm_rdata",   dm_rdata,        32'd0);
      checkOutput("rst_sram_ce",    32'(sram_ce),    32'd0);
      checkOutput("rst_sram_we",    32'(sram_we),    32'd0);
      checkOutput("rst_sram_be",    32'(sram_be),    32'd0);
      checkOutput("rst_sram_addr",  sram_addr,       32'd0);
      checkOutput("rst_sram_wdata", sram_wdata,      32'd0);
      checkOutput("rst_busy",       32'(busy),       32'd0);
   endtask

   // Per-cycle monitor: SRAM pin window and contents, busy, single grant, completion pulses
   always @(negedge clk) begin : monitor
      logic exp_ce;
      logic exp_busy;
      exp_t e;
      if (rst) begin
         exp_if_rdata = 32'h0;
         exp_dm_rdata = 32'h0;
      end else begin
         checkOutput("single_gnt", 32'(if_gnt & dm_gnt), 32'd0);
         exp_ce   = (cyc > g_cyc) && (cyc <= g_cyc + LAT) && (cyc <= abort_cyc);
         exp_busy = (cyc > g_cyc) && (cyc <= g_cyc + LAT + 1) && (cyc <= abort_cyc);
         checkOutput("sram_ce", 32'(sram_ce), 32'(exp_ce));
         checkOutput("busy", 32'(busy), 32'(exp_busy));
         if (sram_ce) begin
            checkOutput("sram_addr", sram_addr, cur_addr);
            checkOutput("sram_we", 32'(sram_we), 32'(cur_we));
            checkOutput("sram_be", 32'(sram_be), 32'(cur_be));
            if (sram_we) checkOutput("sram_wdata", sram_wdata, cur_wdata);
         end
         if (if_rvalid) begin
            if (if_q.size() == 0) begin
               checkOutput("if_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
               e = if_q.pop_front();
               checkOutput("if_rvalid_cycle", 32'(cyc), 32'(e.cyc));
               checkOutput("if_rdata", if_rdata, e.data);
               exp_if_rdata = e.data;
               checkOutput("dm_rdata_hold", dm_rdata, exp_dm_rdata);
            end
         end
         if (dm_done) begin
            if (dm_q.size() == 0) begin
               checkOutput("dm_done_unexpected", 32'd1, 32'd0);
            end else begin
               e = dm_q.pop_front();
               checkOutput("dm_done_cycle", 32'(cyc), 32'(e.cyc));
               if (e.load) begin
                  checkOutput("dm_rdata", dm_rdata, e.data);
                  exp_dm_rdata = e.data;
               end else begin
                  checkOutput("dm_rdata_store_hold", dm_rdata, exp_dm_rdata);
               end
               checkOutput("if_rdata_hold", if_rdata, exp_if_rdata);
            end
         end
      end
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   // Main sequence
   initial begin : stim
      int base, g, g2, gi, gd, gr, gf, w;
      logic [31:0] exp_data;
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
      b_if_req = 1'b0;
      nextCycle();
      doReset();
      checkReset();

      // Both requesters held from reset: DM, IF, DM, IF at cycles 0, 4, 8, 12
      rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h1C00_0000;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200; dm_wdata = 32'h0; dm_be = 4'h0;
      nextCycle();
      nextCycle();
      rst = 1'b0;
      g_cyc = -100;
      abort_cyc = 1 << 30;
      base = cyc;
      for (int k = 0; k < 4; k++) begin
         w = 0;
         #1;
         while (!(if_gnt || dm_gnt) && w < 10) begin
            nextCycle();
            #1;
            w++;
         end
         if (if_gnt || dm_gnt) begin
            checkOutput("conflict_gnt_cycle", 32'(cyc - base), 32'(4 * k));
            checkOutput("conflict_gnt_is_dm", 32'(dm_gnt), 32'(k % 2 == 0));
            if (dm_gnt) pushGrant(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'hCAFE_0200);
            else        pushGrant(1'b0, 1'b0, 32'h1C00_0000, 32'h0, 4'h0, 32'h02C0_0421);
         end else begin
            checkOutput("conflict_gnt_timeout", 32'd0, 32'd1);
         end
         nextCycle();
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      waitUntil(g_cyc + LAT + 2);

      // Reset clears the read-data registers populated above
      doReset();
      checkReset();

      // IF-only read
      applyStimulus(1'b0, 1'b0, 32'h1C00_0000, 32'h0, 4'h0, 32'h02C0_0421, cyc, g);
      waitUntil(g + LAT + 2);

      // DM store then immediately queued load of the same word
      applyStimulus(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 32'h0, cyc, g);
      applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678, 4'h0, 32'h0000_BEEF,
                    g + LAT + 2, g2);
      waitUntil(g2 + LAT + 2);

      // DM request raised one cycle into an IF access waits for the next IDLE
      applyStimulus(1'b0, 1'b0, 32'h1C00_0000, 32'h0, 4'h0, 32'h02C0_0421, cyc, gi);
      applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h5555_AAAA, 4'h0, 32'hCAFE_0200,
                    gi + LAT + 2, gd);
      waitUntil(gd + LAT + 2);

      // Reset during the second cycle of a DM load abandons it without dm_done
      exp_data = 32'hCAFE_0200;
      applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, exp_data, cyc, gr);
      nextCycle();
      rst = 1'b1;
      abort_cyc = cyc;
      if (dm_q.size() > 0) void'(dm_q.pop_back());
      nextCycle();
      rst = 1'b0;
      #1;
      checkOutput("abort_sram_ce", 32'(sram_ce), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_dm_done", 32'(dm_done), 32'd0);
      checkOutput("abort_dm_rdata", dm_rdata, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h1C00_0000, 32'h0, 4'h0, 32'h02C0_0421, cyc, gf);
      waitUntil(gf + LAT + 4);

      // SRAM_LAT = 1 instance: back-to-back IF grants at 0 and 3, pulses at 2 and 5
      b_if_req = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (i == 4) b_if_req = 1'b0;
         #1;
         checkOutput("lat1_if_gnt", 32'(b_if_gnt), 32'(i == 0 || i == 3));
         checkOutput("lat1_sram_ce", 32'(b_sram_ce), 32'(i == 1 || i == 4));
         checkOutput("lat1_if_rvalid", 32'(b_if_rvalid), 32'(i == 2 || i == 5));
         checkOutput("lat1_busy", 32'(b_busy), 32'(i == 1 || i == 2 || i == 4 || i == 5));
         if (b_sram_ce) checkOutput("lat1_sram_addr", b_sram_addr, 32'h0000_0040);
         if (i == 2 || i == 5) checkOutput("lat1_if_rdata", b_if_rdata, 32'hFFFF_FFBF);
         nextCycle();
      end

      nextCycle();
      checkOutput("if_pending", 32'(if_q.size()), 32'd0);
      checkOutput("dm_pending", 32'(dm_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
